float_to_int: RTL and testbench

- Fully pipelined IEEE-754 binary32 to signed 32-bit integer converter; the inverse of the int-to-float unit in the ML datapath subunits.
- Accepts one operand per clock and produces one result per clock at fixed latency.
- Used where accumulated fp32 results re-enter integer/quantized paths.
- Rounding is selectable; out-of-range inputs saturate.

---
 rtl/float_to_int_pkg.sv | 34 +++
 rtl/float_to_int_if.sv | 30 +++
 rtl/float_to_int_align.sv | 45 ++++
 rtl/float_to_int.sv | 200 ++++++++++++++++++++
 tb/tb_float_to_int.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/float_to_int_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : float_to_int_pkg
//  Description : Shared fp32 field constants, integer saturation limits,
//                rounding-mode encodings and the packed fp32 field typedef
//                for the float-to-int converter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package float_to_int_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    // Exponent at which the significand LSB has weight 1 (2^23 * 2^-23).
    localparam logic [8:0] EXP_UNIT = 9'(BIAS + FRAC_W);
    // Smallest exponent whose magnitude reaches 2^31.
    localparam logic [7:0] EXP_BIG  = 8'(BIAS + 31);
    localparam logic [7:0] EXP_MAX  = 8'hFF;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam int RM_RNE = 0;
    localparam int RM_RTZ = 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage
`default_nettype wire

// File: rtl/float_to_int_if.sv
`default_nettype none
// ============================================================================
//  Module      : float_to_int_if
//  Description : Operand/result bundle for the float-to-int converter.
//                The flags member and its modport entries exist only when
//                FLOAT_TO_INT_FLAGS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface float_to_int_if;

    logic        valid_in;
    logic [31:0] input_a;
    logic        valid_out;
    logic [31:0] output_z;
`ifdef FLOAT_TO_INT_FLAGS_EN
    logic [2:0]  flags;

    modport master (output valid_in, output input_a,
                    input  valid_out, input output_z, input flags);
    modport slave  (input  valid_in, input input_a,
                    output valid_out, output output_z, output flags);
`else
    modport master (output valid_in, output input_a,
                    input  valid_out, input output_z);
    modport slave  (input  valid_in, input input_a,
                    output valid_out, output output_z);
`endif

endinterface
`default_nettype wire

// File: rtl/float_to_int_align.sv
`default_nettype none
// ============================================================================
//  Module      : f2i_align
//  Description : Combinational barrel shifter. Scales a 24-bit significand
//                by 2^sh, producing a 31-bit integer magnitude plus the
//                guard, round and sticky bits lost on a right shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module f2i_align (
    input  logic [23:0]       i_m,
    input  logic signed [8:0] i_sh,
    output logic [30:0]       o_mag,
    output logic              o_guard,
    output logic              o_round,
    output logic              o_sticky
);

    logic [8:0]  w_rsh;
    logic [49:0] w_ext;

    assign w_rsh = 9'(-i_sh);

    // Left shift for non-negative sh (only sh <= 7 is ever in range), else
    // right shift through a 26-bit extension that collects the lost bits.
    always_comb begin
        o_mag    = '0;
        o_guard  = 1'b0;
        o_round  = 1'b0;
        o_sticky = 1'b0;
        w_ext    = '0;
        if (!i_sh[8]) begin
            o_mag = {7'b0, i_m} << i_sh[2:0];
        end else if (w_rsh >= 9'd26) begin
            o_sticky = |i_m;
        end else begin
            w_ext    = {i_m, 26'b0} >> w_rsh[4:0];
            o_mag    = {7'b0, w_ext[49:26]};
            o_guard  = w_ext[25];
            o_round  = w_ext[24];
            o_sticky = |w_ext[23:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/float_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : float_to_int
//  Description : Five-stage pipelined fp32 -> signed int32 converter with
//                selectable rounding (ROUND_MODE) and saturation. Optional
//                exception flags when FLOAT_TO_INT_FLAGS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_to_int
    import float_to_int_pkg::*;
#(
    parameter int ROUND_MODE = RM_RNE
) (
    input  logic          clk,
    input  logic          rst,
    float_to_int_if.slave bus
);

    // ---------------- stage 1 : input capture ----------------
    logic  r_s1_valid;
    fp32_t r_s1_fp;

    // Register the raw operand fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_fp    <= '0;
        end else begin
            r_s1_valid <= bus.valid_in;
            r_s1_fp    <= fp32_t'(bus.input_a);
        end
    end

    // ---------------- stage 2 : unpack / classify ----------------
    logic              r_s2_valid, r_s2_sign, r_s2_nan, r_s2_big, r_s2_negmin;
    logic [23:0]       r_s2_m;
    logic signed [8:0] r_s2_sh;

    // Zero/denormal collapses to a zero significand so the result is exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_nan    <= 1'b0;
            r_s2_big    <= 1'b0;
            r_s2_negmin <= 1'b0;
            r_s2_m      <= '0;
            r_s2_sh     <= '0;
        end else begin
            r_s2_valid  <= r_s1_valid;
            r_s2_sign   <= r_s1_fp.sign;
            r_s2_nan    <= (r_s1_fp.exp == EXP_MAX) && (r_s1_fp.frac != '0);
            r_s2_big    <= (r_s1_fp.exp >= EXP_BIG);
            r_s2_negmin <= r_s1_fp.sign && (r_s1_fp.exp == EXP_BIG) && (r_s1_fp.frac == '0);
            r_s2_m      <= (r_s1_fp.exp == '0) ? 24'd0 : {1'b1, r_s1_fp.frac};
            r_s2_sh     <= $signed({1'b0, r_s1_fp.exp} - EXP_UNIT);
        end
    end

    // ---------------- stage 3 : align ----------------
    logic [30:0] w_s2_mag;
    logic        w_s2_guard, w_s2_round, w_s2_sticky;

    f2i_align u_align (
        .i_m      (r_s2_m),
        .i_sh     (r_s2_sh),
        .o_mag    (w_s2_mag),
        .o_guard  (w_s2_guard),
        .o_round  (w_s2_round),
        .o_sticky (w_s2_sticky)
    );

    logic        r_s3_valid, r_s3_sign, r_s3_nan, r_s3_big, r_s3_negmin;
    logic [30:0] r_s3_mag;
    logic        r_s3_guard, r_s3_round, r_s3_sticky;

    // Register the aligned magnitude and the bits shifted out below it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid  <= 1'b0;
            r_s3_sign   <= 1'b0;
            r_s3_nan    <= 1'b0;
            r_s3_big    <= 1'b0;
            r_s3_negmin <= 1'b0;
            r_s3_mag    <= '0;
            r_s3_guard  <= 1'b0;
            r_s3_round  <= 1'b0;
            r_s3_sticky <= 1'b0;
        end else begin
            r_s3_valid  <= r_s2_valid;
            r_s3_sign   <= r_s2_sign;
            r_s3_nan    <= r_s2_nan;
            r_s3_big    <= r_s2_big;
            r_s3_negmin <= r_s2_negmin;
            r_s3_mag    <= w_s2_mag;
            r_s3_guard  <= w_s2_guard;
            r_s3_round  <= w_s2_round;
            r_s3_sticky <= w_s2_sticky;
        end
    end

    // ---------------- stage 4 : round ----------------
    logic        w_s3_inc, w_s3_ovf;
    logic [32:0] w_s3_rounded;

    assign w_s3_inc     = (ROUND_MODE == RM_RNE) ?
                          (r_s3_guard & (r_s3_round | r_s3_sticky | r_s3_mag[0])) : 1'b0;
    assign w_s3_rounded = {2'b0, r_s3_mag} + {32'd0, w_s3_inc};
    // -2^31 exactly is representable, so it is the one big value exempt.
    assign w_s3_ovf     = (r_s3_big & ~r_s3_negmin) | (w_s3_rounded > {1'b0, INT_MAX});

    logic        r_s4_valid, r_s4_sign, r_s4_nan, r_s4_negmin, r_s4_ovf;
    logic [31:0] r_s4_mag;
`ifdef FLOAT_TO_INT_FLAGS_EN
    logic        r_s4_inexact;
`endif

    // Register the rounded magnitude and the saturation decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s4_valid  <= 1'b0;
            r_s4_sign   <= 1'b0;
            r_s4_nan    <= 1'b0;
            r_s4_negmin <= 1'b0;
            r_s4_ovf    <= 1'b0;
            r_s4_mag    <= '0;
        end else begin
            r_s4_valid  <= r_s3_valid;
            r_s4_sign   <= r_s3_sign;
            r_s4_nan    <= r_s3_nan;
            r_s4_negmin <= r_s3_negmin;
            r_s4_ovf    <= w_s3_ovf;
            r_s4_mag    <= w_s3_rounded[31:0];
        end
    end

`ifdef FLOAT_TO_INT_FLAGS_EN
    // Carry the lost-bits indication alongside the rounded magnitude.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s4_inexact <= 1'b0;
        end else begin
            r_s4_inexact <= r_s3_guard | r_s3_round | r_s3_sticky;
        end
    end
`endif

    // ---------------- stage 5 : negate / saturate ----------------
    logic [31:0] w_s4_z;

    // NaN and negative saturation share INT_MIN; otherwise apply the sign.
    always_comb begin
        w_s4_z = r_s4_mag;
        if (r_s4_nan) begin
            w_s4_z = INT_MIN;
        end else if (r_s4_ovf) begin
            w_s4_z = r_s4_sign ? INT_MIN : INT_MAX;
        end else if (r_s4_negmin) begin
            w_s4_z = INT_MIN;
        end else if (r_s4_sign) begin
            w_s4_z = 32'd0 - r_s4_mag;
        end
    end

    logic        r_s5_valid;
    logic [31:0] r_s5_z;

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s5_valid <= 1'b0;
            r_s5_z     <= '0;
        end else begin
            r_s5_valid <= r_s4_valid;
            r_s5_z     <= w_s4_z;
        end
    end

    assign bus.valid_out = r_s5_valid;
    assign bus.output_z  = r_s5_z;

`ifdef FLOAT_TO_INT_FLAGS_EN
    logic [2:0] r_s5_flags;

    // Flags {invalid, overflow, inexact}; NaN masks the other two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s5_flags <= '0;
        end else begin
            r_s5_flags <= {r_s4_nan,
                           r_s4_ovf & ~r_s4_nan,
                           r_s4_inexact & ~r_s4_nan & ~r_s4_ovf};
        end
    end

    assign bus.flags = r_s5_flags;
`endif

endmodule
`default_nettype wire

// File: tb/tb_float_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_to_int
//  Description : Scoreboard bench for float_to_int. Two instances (round to
//                nearest even and truncate) share one stimulus stream; an
//                arithmetic reference model predicts each result and its
//                arrival cycle. Honours FLOAT_TO_INT_FLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] input_a;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    float_to_int_if bus0 ();
    float_to_int_if bus1 ();

    assign bus0.valid_in = valid_in;
    assign bus0.input_a  = input_a;
    assign bus1.valid_in = valid_in;
    assign bus1.input_a  = input_a;

    float_to_int #(.ROUND_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    float_to_int #(.ROUND_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [1:0]  mv;
    logic [31:0] mz [2];
    assign mv[0] = bus0.valid_out;
    assign mv[1] = bus1.valid_out;
    assign mz[0] = bus0.output_z;
    assign mz[1] = bus1.output_z;
`ifdef FLOAT_TO_INT_FLAGS_EN
    logic [2:0] mf [2];
    assign mf[0] = bus0.flags;
    assign mf[1] = bus1.flags;
`endif

    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] z;
        logic [2:0]  fl;
    } sb_t;

    sb_t sbq [2][$];
    sb_t mon_e;

    // Value-level model: x = m * 2^(e-150); round the real quotient.
    function automatic void ref_model(input logic [31:0] a, input int rm,
                                      output logic [31:0] z, output logic [2:0] fl);
        logic          s;
        int            e, k, r;
        longint        m, q, rem, half;
        logic [31:0]   qq;
        logic          inx;
        s   = a[31];
        e   = int'(a[30:23]);
        m   = longint'({1'b1, a[22:0]});
        inx = 1'b0;
        z   = 32'd0;
        fl  = 3'b000;
        if (e == 255 && a[22:0] != 23'd0) begin
            z  = 32'h8000_0000;
            fl = 3'b100;
        end else if (e == 0) begin
            z  = 32'd0;
        end else if (e >= 158) begin
            if (s && e == 158 && a[22:0] == 23'd0) begin
                z = 32'h8000_0000;
            end else begin
                z  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                fl = 3'b010;
            end
        end else begin
            k = e - 150;
            if (k >= 0) begin
                q = m << k;
            end else begin
                r = -k;
                if (r >= 25) begin
                    q   = 0;
                    inx = 1'b1;
                end else begin
                    q    = m >> r;
                    rem  = m - (q << r);
                    half = longint'(1) << (r - 1);
                    inx  = (rem != 0);
                    if (rm == 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
                end
            end
            if (q > 64'sd2147483647) begin
                z  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                fl = 3'b010;
            end else begin
                qq = q[31:0];
                z  = s ? (32'd0 - qq) : qq;
                fl = {2'b00, inx};
            end
        end
    endfunction

    // Drive one operand for one cycle; predictions are due 5 edges on.
    task automatic issue(input logic [31:0] a);
        sb_t ent;
        valid_in = 1'b1;
        input_a  = a;
        for (int i = 0; i < 2; i++) begin
            ent.due = cyc + 5;
            ent.a   = a;
            ref_model(a, i, ent.z, ent.fl);
            sbq[i].push_back(ent);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic zero_data);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b0;
            input_a  = zero_data ? 32'd0 : $urandom;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        logic [22:0] fr;
        int          sel;
        sel = int'($urandom_range(0, 3));
        fr  = 23'($urandom);
        if (sel == 0) begin
            v = $urandom;
        end else if (sel == 1) begin
            v = {1'($urandom), 8'($urandom_range(120, 160)), fr};
        end else begin
            // Few significant bits below the binary point -> exact ties.
            fr = fr & (23'h7FFFFF << $urandom_range(16, 22));
            v  = {1'($urandom), 8'($urandom_range(124, 152)), fr};
        end
        return v;
    endfunction

    // Scoreboard monitor: every valid_out must match the queue head on time.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            while (sbq[i].size() > 0 && sbq[i][0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_out[%0d] in=%h got valid_out=0 required z=%h at cycle %0d",
                         i, sbq[i][0].a, sbq[i][0].z, sbq[i][0].due);
                void'(sbq[i].pop_front());
            end
            if (mv[i]) begin
                n_tests++;
                if (sbq[i].size() == 0 || sbq[i][0].due != cyc) begin
                    n_fail++;
                    $display("FAIL unexpected_valid[%0d] cycle %0d got z=%h required no valid_out",
                             i, cyc, mz[i]);
                end else begin
                    mon_e = sbq[i].pop_front();
`ifdef FLOAT_TO_INT_FLAGS_EN
                    if (mz[i] !== mon_e.z || mf[i] !== mon_e.fl) begin
                        n_fail++;
                        $display("FAIL result[%0d] in=%h got z=%h flags=%b required z=%h flags=%b",
                                 i, mon_e.a, mz[i], mf[i], mon_e.z, mon_e.fl);
                    end
`else
                    if (mz[i] !== mon_e.z) begin
                        n_fail++;
                        $display("FAIL result[%0d] in=%h got z=%h required z=%h",
                                 i, mon_e.a, mz[i], mon_e.z);
                    end
`endif
                end
            end
        end
    end

    task automatic check_quiet(input string name);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (mv[i] !== 1'b0 || mz[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL %s[%0d] got valid_out=%b z=%h required valid_out=0 z=00000000",
                         name, i, mv[i], mz[i]);
            end
        end
    endtask

    logic [31:0] directed [16];

    initial begin
        directed = '{32'h40200000, 32'h40600000, 32'hC0200000, 32'h3F000000,
                     32'h4EFFFFFF, 32'h4F000000, 32'hCF000000, 32'hFF800000,
                     32'h7FC00000, 32'h80000000, 32'h00000001, 32'h7F800000,
                     32'h3FC00000, 32'hBF7FFFFF, 32'h3EFFFFFF, 32'hCF000001};
        rst      = 1'b1;
        valid_in = 1'b0;
        input_a  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_state");
        rst = 1'b0;

        // Lone 1.0: single result, no other valid cycles.
        issue(32'h3F800000);
        idle(8, 1'b0);

        foreach (directed[i]) issue(directed[i]);
        idle(3, 1'b0);

        // Streaming with random gaps.
        for (int n = 0; n < 300; n++) begin
            issue(rand_fp());
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)), 1'b0);
        end
        idle(8, 1'b0);

        // Mid-stream reset with three operands in flight.
        issue(32'h41200000);
        issue(32'hC1200000);
        issue(32'h42C80000);
        rst      = 1'b1;
        valid_in = 1'b0;
        input_a  = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) sbq[i].delete();
        for (int c = 0; c < 7; c++) begin
            check_quiet("post_reset_idle");
            idle(1, 1'b1);
        end
        issue(32'h40E00000);
        idle(8, 1'b0);

        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (sbq[i].size() != 0) begin
                n_fail++;
                $display("FAIL drain[%0d] got %0d pending results required 0", i, sbq[i].size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
